rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 10 +
 rtl/rr_arbiter_pick.sv | 35 +++
 rtl/rr_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package rr_arbiter_pkg;
  localparam int unsigned DEF_WIDTH    = 5;
  localparam int unsigned DEF_HOLD_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set, non-excluded request at or
// above the pointer, wrapping at WIDTH-1.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = $clog2(DEF_WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDXW-1:0]  i_ptr,
  input  logic [WIDTH-1:0] i_excl,
  output logic [WIDTH-1:0] o_win,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_any
);
  logic [WIDTH-1:0] w_masked;
  logic [IDXW-1:0]  w_j;

  assign w_masked = i_req & ~i_excl;

  always_comb begin
    o_win = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_j = IDXW'((int'(i_ptr) + i) % WIDTH);
      if (!o_any && w_masked[w_j]) begin
        o_any       = 1'b1;
        o_win[w_j]  = 1'b1;
        o_idx       = w_j;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with back-to-back handoff; optional hold timeout
// enabled by defining RR_ARBITER_TIMEOUT_EN.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [WIDTH-1:0]         req_i,
  input  logic                     done_i,
  output logic [WIDTH-1:0]         gnt_o,
  output logic                     gnt_valid_o,
  output logic [$clog2(WIDTH)-1:0] gnt_idx_o
);
  localparam int IDXW = $clog2(WIDTH);

  arb_state_t       r_state, w_nstate;
  logic [WIDTH-1:0] r_gnt, w_ngnt;
  logic [IDXW-1:0]  r_idx, w_nidx;
  logic [IDXW-1:0]  r_ptr, w_nptr;

  logic [WIDTH-1:0] w_win;
  logic [IDXW-1:0]  w_win_idx;
  logic             w_any;
  logic             w_hold_req;
  logic             w_tmo;
  logic             w_release;
  logic             w_load;

  // The holder is excluded so a release never re-grants it in the same edge.
  rr_pick #(.WIDTH(WIDTH), .IDXW(IDXW)) u_pick (
    .i_req  (req_i),
    .i_ptr  (r_ptr),
    .i_excl (r_gnt),
    .o_win  (w_win),
    .o_idx  (w_win_idx),
    .o_any  (w_any)
  );

  assign w_hold_req = |(req_i & r_gnt);
  assign w_release  = done_i | ~w_hold_req | w_tmo;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int CNTW = $clog2(HOLD_MAX);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(HOLD_MAX - 1);

  logic [CNTW-1:0] r_cnt, w_ncnt;

  // Forced release only when someone else is waiting; otherwise saturate.
  assign w_tmo = (r_state == GRANT) && (r_cnt == CNT_MAX) && w_any;

  always_comb begin
    w_ncnt = r_cnt;
    if (w_load || w_nstate == IDLE)
      w_ncnt = '0;
    else if (r_cnt != CNT_MAX)
      w_ncnt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) r_cnt <= '0;
    else         r_cnt <= w_ncnt;
  end
`else
  logic w_unused_hold;
  assign w_unused_hold = (HOLD_MAX >= 2);
  assign w_tmo         = 1'b0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_ngnt   = r_gnt;
    w_nidx   = r_idx;
    w_nptr   = r_ptr;
    w_load   = 1'b0;
    case (r_state)
      IDLE:    w_load = w_any;
      GRANT: begin
        if (w_release) begin
          w_load = w_any;
          if (!w_any) begin
            w_nstate = IDLE;
            w_ngnt   = '0;
            w_nidx   = '0;
          end
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ngnt   = '0;
        w_nidx   = '0;
      end
    endcase
    if (w_load) begin
      w_nstate = GRANT;
      w_ngnt   = w_win;
      w_nidx   = w_win_idx;
      w_nptr   = (w_win_idx == IDXW'(WIDTH - 1)) ? '0 : w_win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nstate;
      r_gnt   <= w_ngnt;
      r_idx   <= w_nidx;
      r_ptr   <= w_nptr;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = |r_gnt;
  assign gnt_idx_o   = r_idx;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic against an
// integer-level round-robin model.
module tb_rr_arbiter;
  localparam int W  = 5;
  localparam int HM = 4;

  logic         clk_i = 1'b0;
  logic         srst_i;
  logic [W-1:0] req_i;
  logic         done_i;
  logic [W-1:0] gnt_o;
  logic         gnt_valid_o;
  logic [2:0]   gnt_idx_o;

  int errors = 0;
  int checks = 0;

  int m_hold = -1;
  int m_ptr  = 0;
  int m_cnt  = 0;

  rr_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: holder index (-1 = none), rotating priority pointer, hold age.
  task automatic model_edge();
    int  win;
    bit  others;
    bit  rel;
    if (!srst_i) begin
      m_hold = -1; m_ptr = 0; m_cnt = 0;
      return;
    end
    win = -1;
    for (int k = 0; k < W; k++) begin
      int c = (m_ptr + k) % W;
      if (win < 0 && req_i[c] && c != m_hold) win = c;
    end
    others = (win >= 0);
    rel = (m_hold < 0) || done_i || !req_i[m_hold];
`ifdef RR_ARBITER_TIMEOUT_EN
    if (m_hold >= 0 && m_cnt == HM - 1 && others) rel = 1;
`endif
    if (!rel) begin
      if (m_cnt < HM - 1) m_cnt++;
    end else if (others) begin
      m_hold = win; m_ptr = (win + 1) % W; m_cnt = 0;
    end else begin
      m_hold = -1; m_cnt = 0;
    end
  endtask

  function automatic logic [W-1:0] m_gnt();
    logic [W-1:0] g = '0;
    if (m_hold >= 0) g[m_hold] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    srst_i = 1'b0; done_i = 1'b0; req_i = '0;
    tick();
    srst_i = 1'b1;
  endtask

  task automatic test_reset();
    srst_i = 1'b0; req_i = 5'b11111; done_i = 1'b0;
    tick(); tick();
    checks++; if (gnt_o !== 5'b00000) begin errors++; $display("FAIL reset_gnt got=%b want=00000", gnt_o); end
    checks++; if (gnt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", gnt_valid_o); end
    checks++; if (gnt_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", gnt_idx_o); end
    srst_i = 1'b1;
    tick();
    checks++; if (gnt_o !== 5'b00001) begin errors++; $display("FAIL reset_first_gnt got=%b want=00001", gnt_o); end
    checks++; if (gnt_idx_o !== 3'd0) begin errors++; $display("FAIL reset_first_idx got=%0d want=0", gnt_idx_o); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    req_i = 5'b11111; done_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (gnt_o !== exp[i] || gnt_valid_o !== 1'b1) begin
        errors++; $display("FAIL b2b_step%0d got=%b/%b want=%b/1", i, gnt_o, gnt_valid_o, exp[i]);
      end
    end
    done_i = 1'b0;
  endtask

  task automatic test_alternate();
    logic [W-1:0] exp [5] = '{5'b00100, 5'b10000, 5'b10000, 5'b00100, 5'b00100};
    logic         dn  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    req_i = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      done_i = dn[i];
      tick();
      checks++; if (gnt_o !== exp[i]) begin
        errors++; $display("FAIL alt_step%0d got=%b want=%b", i, gnt_o, exp[i]);
      end
    end
    done_i = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    req_i = 5'b00010;
    tick();
    checks++; if (gnt_o !== 5'b00010) begin errors++; $display("FAIL drop_first got=%b want=00010", gnt_o); end
    req_i = 5'b01000;
    tick();
    checks++; if (gnt_o !== 5'b01000 || gnt_idx_o !== 3'd3) begin
      errors++; $display("FAIL drop_handoff got=%b/%0d want=01000/3", gnt_o, gnt_idx_o);
    end
    req_i = 5'b01000;
    tick();
    checks++; if (gnt_o !== 5'b01000) begin errors++; $display("FAIL drop_hold got=%b want=01000", gnt_o); end
    req_i = 5'b00000;
    tick();
    checks++; if (gnt_o !== 5'b00000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 3'd0) begin
      errors++; $display("FAIL drop_idle got=%b/%b/%0d want=00000/0/0", gnt_o, gnt_valid_o, gnt_idx_o);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] want;
    do_reset();
    req_i = 5'b00011; done_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef RR_ARBITER_TIMEOUT_EN
      want = (i < 4) ? 5'b00001 : 5'b00010;
`else
      want = 5'b00001;
`endif
      checks++; if (gnt_o !== want) begin
        errors++; $display("FAIL timeout_step%0d got=%b want=%b", i, gnt_o, want);
      end
    end
    // Sole requester must keep its grant indefinitely, timeout or not.
    req_i = (gnt_o == 5'b00010) ? 5'b00010 : 5'b00001;
    want  = req_i;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (gnt_o !== want) begin
        errors++; $display("FAIL timeout_sat%0d got=%b want=%b", i, gnt_o, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 5'b01000;
    tick();
    checks++; if (gnt_o !== 5'b01000) begin errors++; $display("FAIL rstmid_grant got=%b want=01000", gnt_o); end
    srst_i = 1'b0;
    tick();
    checks++; if (gnt_o !== 5'b00000 || gnt_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got=%b/%b want=00000/0", gnt_o, gnt_valid_o);
    end
    srst_i = 1'b1; req_i = 5'b11000;
    tick();
    checks++; if (gnt_o !== 5'b01000 || gnt_idx_o !== 3'd3) begin
      errors++; $display("FAIL rstmid_ptr got=%b/%0d want=01000/3", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] g;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      srst_i = ($urandom_range(0, 49) != 0);
      req_i  = W'($urandom);
      if ($urandom_range(0, 2) == 0) req_i = '0;
      done_i = ($urandom_range(0, 3) == 0);
      tick();
      g = m_gnt();
      checks++; if (gnt_o !== g || gnt_valid_o !== (m_hold >= 0) || gnt_idx_o !== 3'((m_hold < 0) ? 0 : m_hold)) begin
        errors++; $display("FAIL rand_cyc%0d got=%b/%b/%0d want=%b/%b/%0d", i, gnt_o, gnt_valid_o, gnt_idx_o,
                           g, (m_hold >= 0), (m_hold < 0) ? 0 : m_hold);
      end
    end
    srst_i = 1'b1;
  endtask

  initial begin
    srst_i = 1'b0; req_i = '0; done_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_alternate();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
